// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
`ifndef SYNC_FIFO_PKG_SV
`define SYNC_FIFO_PKG_SV

// Elaboration-time parameter guard; emits a named generate block only on failure.
`define SYNC_FIFO_CHECK(label, cond, msg) \
   if (!(cond)) begin : label \
      $error(msg); \
   end

package sync_fifo_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   function automatic int clog2(input int value);
      int v;
      int r;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bus of the single-clock FIFO.
interface sync_fifo_flags_if
   import sync_fifo_pkg::*;
#(
   parameter int width      = DEF_WIDTH,
   parameter int addr_width = DEF_ADDR_WIDTH
);
   logic                  w_en;
   logic [width-1:0]      wdata;
   logic                  r_en;
   logic [width-1:0]      rdata;
   logic                  rvalid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [addr_width:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output w_en, wdata, r_en,
      input  rdata, rvalid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  w_en, wdata, r_en,
      output rdata, rvalid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags_ram.sv
// Simple dual-port storage; read port registered or asynchronous.
module fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int width      = DEF_WIDTH,
   parameter int addr_width = DEF_ADDR_WIDTH,
   parameter bit REG_OUT    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [addr_width-1:0] i_waddr,
   input  logic [width-1:0]      i_wdata,
   input  logic                  i_re,
   input  logic [addr_width-1:0] i_raddr,
   output logic [width-1:0]      o_rdata
);
   logic [width-1:0] r_mem [2**addr_width];
   logic [width-1:0] r_rdata;

   // synchronous write port; contents survive reset
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // registered read: loads only on a pop, otherwise holds the last word
   always_ff @(posedge clk) begin
      if (rst)       r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   // in fall-through mode the head word is read straight from the array
   assign o_rdata = REG_OUT ? r_rdata : r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky errors.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int width      = DEF_WIDTH,
   parameter int addr_width = DEF_ADDR_WIDTH,
   parameter bit FWFT       = 1'b0,
   parameter int AF_THRESH  = 2**addr_width - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic               clk,
   input  logic               rst,
   sync_fifo_flags_if.slave   bus
);
   localparam int                  DEPTH   = 2**addr_width;
   localparam logic [addr_width:0] DEPTH_C = (addr_width+1)'(DEPTH);
   localparam logic [addr_width:0] AF_C    = (addr_width+1)'(AF_THRESH);
   localparam logic [addr_width:0] AE_C    = (addr_width+1)'(AE_THRESH);
   localparam logic [addr_width:0] CNT_ONE = (addr_width+1)'(1);
   localparam logic [addr_width-1:0] PTR_ONE = addr_width'(1);

   `SYNC_FIFO_CHECK(g_bad_af_thresh, (AF_THRESH >= 1) && (AF_THRESH <= DEPTH),
                    "sync_fifo_flags: AF_THRESH must lie in 1..depth")
   `SYNC_FIFO_CHECK(g_bad_ae_thresh, (AE_THRESH >= 0) && (AE_THRESH <= DEPTH-1),
                    "sync_fifo_flags: AE_THRESH must lie in 0..depth-1")

   logic [addr_width-1:0] r_rd_ptr;
   logic [addr_width-1:0] r_wr_ptr;
   logic [addr_width:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  r_rvalid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [addr_width:0]   w_cnt_nxt;
   logic [width-1:0]      w_rdata;

   // a full FIFO still takes a write when a pop frees the slot in the same cycle
   assign w_rd_acc = bus.r_en & ~r_empty & ~rst;
   assign w_wr_acc = bus.w_en & (~r_full | w_rd_acc) & ~rst;

   // next occupancy; flags are registered from this value
   always_comb begin
      w_cnt_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_cnt_nxt = r_count + CNT_ONE;
         2'b01:   w_cnt_nxt = r_count - CNT_ONE;
         default: w_cnt_nxt = r_count;
      endcase
   end

   // pointers, count and registered flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_rvalid       <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_count        <= w_cnt_nxt;
         r_full         <= (w_cnt_nxt == DEPTH_C);
         r_empty        <= (w_cnt_nxt == '0);
         r_almost_full  <= (w_cnt_nxt >= AF_C);
         r_almost_empty <= (w_cnt_nxt <= AE_C);
         r_rvalid       <= w_rd_acc;
      end
   end

   // sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.w_en & ~w_wr_acc) r_overflow  <= 1'b1;
         if (bus.r_en & r_empty)   r_underflow <= 1'b1;
      end
   end

   fifo_ram #(
      .width      (width),
      .addr_width (addr_width),
      .REG_OUT    (!FWFT)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.wdata),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign bus.rdata        = w_rdata;
   assign bus.rvalid       = FWFT ? ~r_empty : r_rvalid;
   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_almost_full;
   assign bus.almost_empty = r_almost_empty;
   assign bus.count        = r_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench: one registered-read and one fall-through FIFO driven with identical
// stimulus, checked against a queue model and a popped-word scoreboard.
module tb_sync_fifo_flags;
   import sync_fifo_pkg::*;

   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       w_en  = 1'b0;
   logic       r_en  = 1'b0;
   logic [7:0] wdata = 8'h00;

   always #5 clk = ~clk;

   sync_fifo_flags_if #(.width(8), .addr_width(4)) bus0 ();
   sync_fifo_flags_if #(.width(8), .addr_width(4)) bus1 ();

   assign bus0.w_en  = w_en;
   assign bus0.wdata = wdata;
   assign bus0.r_en  = r_en;
   assign bus1.w_en  = w_en;
   assign bus1.wdata = wdata;
   assign bus1.r_en  = r_en;

   sync_fifo_flags #(.width(8), .addr_width(4), .FWFT(1'b0),
                     .AF_THRESH(AF), .AE_THRESH(AE)) u_dut0 (
      .clk (clk), .rst (rst), .bus (bus0));

   sync_fifo_flags #(.width(8), .addr_width(4), .FWFT(1'b1),
                     .AF_THRESH(AF), .AE_THRESH(AE)) u_dut1 (
      .clk (clk), .rst (rst), .bus (bus1));

   // reference model: contents as a queue, plus sticky bits and the
   // registered-read output word
   logic [7:0] mq [$];
   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];
   bit         m_ovf, m_unf, m_rv0;
   logic [7:0] m_rdata0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_dut(string tag, logic [4:0] cnt, logic e, logic f,
                          logic af, logic ae, logic ov, logic un);
      int n;
      n = mq.size();
      chk({tag, "_count"},        cnt, n);
      chk({tag, "_empty"},        e,   n == 0);
      chk({tag, "_full"},         f,   n == DEPTH);
      chk({tag, "_almost_full"},  af,  n >= AF);
      chk({tag, "_almost_empty"}, ae,  n <= AE);
      chk({tag, "_overflow"},     ov,  m_ovf);
      chk({tag, "_underflow"},    un,  m_unf);
   endtask

   task automatic check_state();
      chk_dut("reg", bus0.count, bus0.empty, bus0.full, bus0.almost_full,
              bus0.almost_empty, bus0.overflow, bus0.underflow);
      chk_dut("fwft", bus1.count, bus1.empty, bus1.full, bus1.almost_full,
              bus1.almost_empty, bus1.overflow, bus1.underflow);
      chk("reg_rvalid",  bus0.rvalid, m_rv0);
      chk("reg_rdata",   bus0.rdata,  m_rdata0);
      chk("fwft_rvalid", bus1.rvalid, mq.size() != 0);
      if (mq.size() != 0) chk("fwft_head", bus1.rdata, mq[0]);
   endtask

   // one clock of stimulus; the model is advanced to the post-edge state
   task automatic step(bit we, logic [7:0] wd, bit re);
      bit rd, wr;
      @(negedge clk); #1;
      rst   = 1'b0;
      w_en  = we;
      wdata = wd;
      r_en  = re;
      rd = re && (mq.size() != 0);
      wr = we && ((mq.size() < DEPTH) || rd);
      if (re && mq.size() == 0) m_unf = 1'b1;
      if (we && !wr)            m_ovf = 1'b1;
      m_rv0 = rd;
      if (rd) begin
         m_rdata0 = mq[0];
         exp0.push_back(mq[0]);
         exp1.push_back(mq[0]);
         void'(mq.pop_front());
      end
      if (wr) mq.push_back(wd);
      @(posedge clk); #1;
      check_state();
   endtask

   // reset cycle with both requests asserted; they must be ignored
   task automatic do_reset();
      @(negedge clk); #1;
      rst   = 1'b1;
      w_en  = 1'b1;
      r_en  = 1'b1;
      wdata = 8'hFF;
      mq.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_rv0    = 1'b0;
      m_rdata0 = 8'h00;
      @(posedge clk); #1;
      check_state();
   endtask

   // registered-read monitor: every rvalid pulse consumes one expected word
   always @(posedge clk) begin
      #2;
      if (bus0.rvalid) begin
         if (exp0.size() == 0) begin
            chk("reg_sb_unexpected", 1, 0);
         end else begin
            chk("reg_sb_data", bus0.rdata, exp0.pop_front());
         end
      end
   end

   // fall-through monitor: the word on rdata when a pop is presented
   always @(negedge clk) begin
      #3;
      if (!rst && bus1.rvalid && r_en) begin
         if (exp1.size() == 0) begin
            chk("fwft_sb_unexpected", 1, 0);
         end else begin
            chk("fwft_sb_data", bus1.rdata, exp1.pop_front());
         end
      end
   end

   initial begin
      int wp, rp;
      do_reset();
      do_reset();

      // mid-stream reset discards stored words
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      do_reset();
      step(1'b0, 8'h00, 1'b0);

      // three writes then three reads
      step(1'b1, 8'hA1, 1'b0);
      step(1'b1, 8'hB2, 1'b0);
      step(1'b1, 8'hC3, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      // fill to full, reject a 17th write, drain across the pointer wrap
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hEE, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // simultaneous write and read while full
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // simultaneous read and write while empty
      do_reset();
      step(1'b1, 8'h7E, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // fall-through visibility of back-to-back writes
      do_reset();
      step(1'b1, 8'h10, 1'b0);
      step(1'b1, 8'h20, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // random traffic in phases biased toward filling, draining and mixing
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         case (ph % 3)
            0:       begin wp = 80; rp = 30; end
            1:       begin wp = 30; rp = 80; end
            default: begin wp = 60; rp = 60; end
         endcase
         for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 99) < wp), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < rp));
         end
      end
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      chk("reg_sb_leftover",  exp0.size(), 0);
      chk("fwft_sb_leftover", exp1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO. Next generation of the team's FIFO family, for same-clock producer/consumer paths where a CDC FIFO is unnecessary.
- Adds features the current FIFO lacks:
  - selectable first-word-fall-through (FWFT) read mode;
  - occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags.

Parameters:
- width, 8, data word width in bits.
- addr_width, 4, log2 of depth; depth = 2**addr_width entries.
- FWFT, 0, read mode:
  - 0: registered read, 1-cycle latency.
  - 1: head word visible on rdata while !empty.
- AF_THRESH, 2**addr_width-2, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- wdata  in  width  write data.
- r_en  in  1  read request (pop).
- rdata  out  width  read data.
- rvalid  out  1  rdata holds a newly popped word. FWFT=0: pulses 1 cycle after each accepted read. FWFT=1: equals !empty.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  addr_width+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a write was attempted while it could not be accepted.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: rst sampled at posedge clk. Reset values:
  - rd_ptr, wr_ptr, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
  - rst asserted mid-operation discards all stored data; w_en and r_en are ignored in the reset cycle.
- Acceptance:
  - rd_acc = r_en & !empty.
  - wr_acc = w_en & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- Pointers and count:
  - Pointers are addr_width bits and wrap naturally from depth-1 to 0.
  - count updates as +1 (wr_acc only), -1 (rd_acc only), or unchanged (both or neither).
  - All flags are registered and derived from the next-count value, so they are valid in the cycle after the edge that changed count.
- Empty plus simultaneous read and write: the read is rejected and underflow is set; the write is accepted. There is no bypass in either mode.
- FWFT=0:
  - On rd_acc, rdata <= mem[rd_ptr] at that edge.
  - rdata holds its value when no read is accepted.
  - rvalid <= rd_acc.
- FWFT=1:
  - rdata = mem[rd_ptr] (asynchronous array read); defined only while !empty.
  - The first write into an empty FIFO becomes visible the cycle after its write edge, when empty falls.
  - r_en pops the head; the next word appears after that edge.
- Errors:
  - overflow <= 1 on w_en & !wr_acc.
  - underflow <= 1 on r_en & empty.
  - Both are cleared only by rst.
- Thresholds: AF_THRESH must be in 1..depth and AE_THRESH in 0..depth-1. Violations are flagged at elaboration with $error.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2;
  - default width and addr_width constants shared with the async FIFO bench;
  - a parameter-check macro.
- One sub-module, fifo_ram:
  - simple dual-port register array, width x 2**addr_width;
  - synchronous write;
  - read port selectable registered/asynchronous via parameter REG_OUT (set to !FWFT).
- Pointer, count and flag logic stay in the top module.

Test Plan (width=8, addr_width=4, AF_THRESH=14, AE_THRESH=2):
- Reset then idle:
  - Required: empty=1, almost_empty=1, full=0, count=0, rdata=00, overflow=0, underflow=0.
  - Assert rst for 1 cycle mid-stream after writing 5 words → count=0, empty=1 next cycle.
- FWFT=0, write A1,B2,C3 then 3 reads:
  - rdata = A1, B2, C3, each 1 cycle after its r_en cycle, with rvalid high on exactly those 3 cycles.
  - empty=1 after the third read.
- Fill 16 words (00..0F):
  - almost_full rises when count=14; full=1 at count=16.
  - A 17th write is rejected: count stays 16 and overflow=1.
  - Reading back returns 00..0F in order, exercising pointer wrap.
- Full with simultaneous w_en=1 (data 55) and r_en=1:
  - count stays 16 and full stays 1.
  - After draining, 55 is the last word read.
- Empty with simultaneous r_en=1 and w_en=1 (data 7E):
  - underflow=1, count=1.
  - FWFT=1: rdata=7E and rvalid=1 on the next cycle.
- FWFT=1, write 10,20 back-to-back:
  - rdata=10 the cycle after the first write; one r_en → rdata=20.
  - almost_empty stays 1 throughout (count <= 2).
